uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter WORD_BYTES, default 4, bytes per transmitted word; legal range 1..8.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tx_word  input  8*WORD_BYTES  word to transmit; sampled only on accept.
REQ-006 tx_valid  input  1  tx_word is valid.
REQ-007 tx_ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  serial line; idle level 1.
REQ-009 busy  output  1  a word is being serialized.
REQ-010 tx_done  output  1  one-cycle pulse: the whole word has been sent.
REQ-011 tx_byte_idx  output  3  index of the byte currently on the line; 0 when idle.

Function
REQ-012 States SHALL be IDLE, START, DATA, STOP; tx_ready = (state==IDLE); busy = !tx_ready.
REQ-013 Accept SHALL occur on a rising edge where tx_valid && tx_ready; tx_word is latched into an internal shift register, byte index = 0, baud counter = 0, state -> START.
REQ-014 tx_valid while not ready SHALL be ignored; no queueing; tx_word changes after accept SHALL NOT affect the frame.
REQ-015 First cycle after accept SHALL drive tx=0 (latency 1 cycle from accept to start bit).
REQ-016 Each byte frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-017 Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary; bit counter 0..7 in DATA.
REQ-018 Bytes SHALL be sent least-significant byte first (tx_word[7:0] first).
REQ-019 At end of a STOP bit with byte index < WORD_BYTES-1: index +1, state -> START with no idle gap.
REQ-020 At end of the STOP bit of the last byte: state -> IDLE, tx_done=1 for exactly that first IDLE cycle, tx_ready=1 in the same cycle.
REQ-021 A word accepted in the tx_done cycle SHALL start normally (start bit the next cycle), giving back-to-back words with no extra idle bits.
REQ-022 Word duration SHALL be exactly WORD_BYTES*10*CLKS_PER_BIT cycles from first start-bit cycle to first IDLE cycle.
REQ-023 tx SHALL be registered (glitch-free); tx=1 in IDLE and STOP.
REQ-024 tx_byte_idx SHALL reflect the byte in START/DATA/STOP and reset to 0 on entering IDLE.

Reset
REQ-025 While reset=1, asynchronously: state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, tx_byte_idx=0, all counters and shift register 0.
REQ-026 Reset mid-frame SHALL abort the word immediately with tx=1; no tx_done pulse; the partial word is discarded.
REQ-027 After reset deasserts, the first rising edge with tx_valid=1 SHALL be a valid accept.

Verification (CLKS_PER_BIT=4, WORD_BYTES=4)
REQ-028 Single word: tx_word=32'h000000A5 accepted at cycle 0 -> tx low cycles 1-4, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, then three 0x00 frames; tx_done pulse at cycle 161, tx_ready low cycles 1-160.
REQ-029 Byte order: tx_word=32'h44332211 -> line decodes bytes 0x11,0x22,0x33,0x44 in order; tx_byte_idx steps 0,1,2,3 at frame starts.
REQ-030 Back-to-back: second word 32'hDEADBEEF presented with tx_valid held -> accepted in tx_done cycle, start bit next cycle, no idle bit between words.
REQ-031 Ignore while busy: pulse tx_valid with 32'hFFFFFFFF at cycle 50 of a word -> no effect; serial output unchanged; only one tx_done.
REQ-032 Reset mid-frame: assert reset during DATA of byte 2 -> tx=1, busy=0, tx_ready=1 immediately without a clock edge; no tx_done; next word after deassert transmits correctly.
REQ-033 Parameter sweep: CLKS_PER_BIT=2 and WORD_BYTES=1 -> 0x3C sent in exactly 20 cycles, tx_done at cycle 21.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: word-wide 8N1 serial transmitter.
// Sends WORD_BYTES bytes LSB-first, each as start, 8 data bits (LSB first) and stop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*WORD_BYTES-1:0] tx_word,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done,
  output logic [2:0]              tx_byte_idx
);

  localparam int          W         = 8 * WORD_BYTES;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BYTE_LAST = 3'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [W-1:0] shreg;
  logic        tx_nxt;
  logic        bit_end;
  logic        accept;
  logic        last_bit;
  logic        last_byte;
  logic        word_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign accept    = (state == IDLE) && tx_valid;
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_idx == BYTE_LAST);
  assign word_end  = (state == STOP) && bit_end && last_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end && last_bit) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = last_byte ? IDLE : START;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered, so its next value is chosen from the next state.
  // The register shifts at each data-bit end, so the upcoming bit is
  // shreg[0] on entry from START and shreg[1] on a data-bit boundary.
  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    tx_nxt   = tx;
    unique case (1'b1)
      state_nxt == IDLE,
      state_nxt == STOP: tx_nxt = 1'b1;
      state_nxt == START: tx_nxt = 1'b0;
      state_nxt == DATA: begin
        if (state == START) begin
          tx_nxt = shreg[0];
        end else if (bit_end) begin
          tx_nxt = shreg[1];
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      tx_done <= word_end;
      if (accept) begin
        shreg    <= tx_word;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        byte_idx <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
        if (state == DATA && bit_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          shreg   <= shreg >> 1;
        end
        if (state == STOP && bit_end) begin
          byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
        end
      end
    end
  end

  assign tx_byte_idx = byte_idx;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: cycle-level model plus line decoder for uart_tx,
// with table vectors, random words and a small-parameter instance.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready, tx, busy, tx_done;
  logic [2:0]  tx_byte_idx;

  logic [7:0]  w2;
  logic        v2;
  logic        rdy2, tx2, busy2, done2;
  logic [2:0]  idx2;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .WORD_BYTES(WB)) dut (
    .clk(clk), .reset(reset), .tx_word(tx_word), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .tx_done(tx_done),
    .tx_byte_idx(tx_byte_idx)
  );

  uart_tx #(.CLKS_PER_BIT(2), .WORD_BYTES(1)) dut2 (
    .clk(clk), .reset(reset), .tx_word(w2), .tx_valid(v2),
    .tx_ready(rdy2), .tx(tx2), .busy(busy2), .tx_done(done2),
    .tx_byte_idx(idx2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every accepted word becomes a list of expected line cycles.
  typedef struct packed {
    logic       tx;
    logic [2:0] idx;
  } ln_t;

  ln_t  mq[$];
  logic m_done = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_done = 1'b0;
      end else begin
        logic was_idle;
        was_idle = (mq.size() == 0);
        m_done = 1'b0;
        if (!was_idle) begin
          mq.delete(0);
          if (mq.size() == 0) m_done = 1'b1;
        end
        if (was_idle && tx_valid) begin
          for (int b = 0; b < WB; b++) begin
            for (int p = 0; p < 10; p++) begin
              logic v;
              v = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : tx_word[8*b+p-1];
              repeat (C) mq.push_back('{v, 3'(b)});
            end
          end
        end
      end
    end
  end

  // Per-cycle compare, tx_done counter and an independent line decoder.
  logic [7:0] rxq[$];
  logic [7:0] rx_sh;
  int         rx_cnt;
  logic       rx_act = 1'b0;
  int         dcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_act = 1'b0;
      end else begin
        logic       etx, erdy, edone;
        logic [2:0] eidx;
        if (mq.size() != 0) begin
          etx = mq[0].tx; eidx = mq[0].idx; erdy = 1'b0; edone = 1'b0;
        end else begin
          etx = 1'b1; eidx = 3'd0; erdy = 1'b1; edone = m_done;
        end
        check("cycle", {tx, tx_ready, busy, tx_done, tx_byte_idx},
              {etx, erdy, !erdy, edone, eidx});
        if (tx_done) dcnt++;
        if (!rx_act) begin
          if (!tx) begin
            rx_act = 1'b1; rx_cnt = 0; rx_sh = 8'h00;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt > C && rx_cnt < 9*C && (rx_cnt % C) == C/2) begin
            rx_sh = {tx, rx_sh[7:1]};
          end else if (rx_cnt == 9*C + C/2) begin
            check("stop_bit", tx, 1);
            rxq.push_back(rx_sh);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("ready_timeout", 0, 1);
    rxq.delete();
    tx_word  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_word  = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < 2000);
    if (n >= 2000) check("done_timeout", 0, 1);
  endtask

  task automatic check_rx(input logic [7:0] exq[$]);
    check("rx_count", rxq.size(), exq.size());
    for (int i = 0; i < exq.size(); i++) begin
      check($sformatf("rx_byte%0d", i),
            (i < rxq.size()) ? rxq[i] : 8'hxx, exq[i]);
    end
  endtask

  typedef struct {
    logic [31:0]      word;
    logic [0:3][7:0]  seq;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] exq[$];
  int         n, d0;
  logic [31:0] w;
  logic [9:0]  f;

  initial begin
    tbl[0] = '{32'h000000A5, {8'hA5, 8'h00, 8'h00, 8'h00}};
    tbl[1] = '{32'h44332211, {8'h11, 8'h22, 8'h33, 8'h44}};
    tbl[2] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[3] = '{32'h80000001, {8'h01, 8'h00, 8'h00, 8'h80}};
    tbl[4] = '{32'hDEADBEEF, {8'hEF, 8'hBE, 8'hAD, 8'hDE}};
    tbl[5] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};

    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_word  = '0;
    v2       = 1'b0;
    w2       = '0;
    #2 reset = 1'b1;
    #1;
    check("reset_state", {tx, tx_ready, busy, tx_done, tx_byte_idx}, 7'b1100000);
    check("reset_state2", {tx2, rdy2, busy2, done2, idx2}, 7'b1100000);
    #20 reset = 1'b0;

    // Table vectors: line bytes and word length.
    for (int k = 0; k < 6; k++) begin
      send(tbl[k].word);
      wait_done(n);
      check($sformatf("vec%0d_len", k), n, 161);
      exq.delete();
      for (int i = 0; i < 4; i++) exq.push_back(tbl[k].seq[i]);
      check_rx(exq);
    end

    // Back-to-back: second word accepted in the tx_done cycle.
    @(negedge clk);
    while (!tx_ready) @(negedge clk);
    rxq.delete();
    tx_word  = 32'h12345678;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_word = 32'hDEADBEEF;
    wait_done(n);
    check("b2b_first_len", n, 161);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check("b2b_start_bit", {tx, busy}, 2'b01);
    wait_done(n);
    check("b2b_second_len", n, 161);
    exq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_rx(exq);

    // tx_valid pulsed mid-word is ignored.
    d0 = dcnt;
    send(32'h0F1E2D3C);
    repeat (50) @(negedge clk);
    tx_word  = 32'hFFFFFFFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done(n);
    repeat (5) @(negedge clk);
    check("ignore_done_cnt", dcnt - d0, 1);
    exq = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};
    check_rx(exq);

    // Asynchronous reset during DATA of byte 2.
    send(32'hA1B2C3D4);
    n = 0;
    while (tx_byte_idx != 3'd2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("idx2_timeout", 0, 1);
    repeat (6) @(negedge clk);
    d0 = dcnt;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_async", {tx, tx_ready, busy, tx_done, tx_byte_idx}, 7'b1100000);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (200) @(negedge clk);
    check("reset_no_done", dcnt - d0, 0);
    send(32'h5AC3_7E81);
    wait_done(n);
    check("post_reset_len", n, 161);
    exq = '{8'h81, 8'h7E, 8'hC3, 8'h5A};
    check_rx(exq);

    // Random words, sometimes with an ignored mid-word request.
    for (int k = 0; k < 12; k++) begin
      w = $urandom;
      d0 = dcnt;
      send(w);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 150)) @(negedge clk);
        tx_word  = $urandom;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      wait_done(n);
      exq.delete();
      for (int i = 0; i < 4; i++) exq.push_back(w[8*i +: 8]);
      check_rx(exq);
      check("rand_done_cnt", dcnt - d0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Small instance: 2 clocks per bit, single byte.
    @(negedge clk);
    w2 = 8'h3C;
    v2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    w2 = 8'hFF;
    f  = {1'b1, 8'h3C, 1'b0};
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c <= 20) begin
        check($sformatf("sweep_c%0d", c), {tx2, rdy2, busy2, done2, idx2},
              {f[(c-1)/2], 1'b0, 1'b1, 1'b0, 3'd0});
      end else begin
        check("sweep_done", {tx2, rdy2, busy2, done2, idx2}, 7'b1101000);
      end
    end
    @(negedge clk);
    check("sweep_idle", {tx2, rdy2, done2}, 3'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
